// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : load_store_unit
// Purpose  : One-at-a-time load/store controller in front of a word-addressed
//            memory; RMW for sub-word stores, extended load data to writeback.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_data
);

  localparam logic [29:0] WORD_LIMIT = 30'(NUM_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;

  logic        illegal_w, misalign_w, range_w, fault_w;
  logic [4:0]  shamt_w;
  logic [31:0] shifted_w, load_ext_w, lane_mask_w, merged_w;

  // Request screening is done on the live inputs so a fault costs no memory cycle.
  always_comb begin
    illegal_w  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_store && req_funct3[2]);
    misalign_w = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    range_w    = (req_addr[31:2] >= WORD_LIMIT);
    fault_w    = illegal_w || misalign_w || range_w;
  end

  always_comb begin
    shamt_w     = {addr_q[1:0], 3'b000};
    shifted_w   = mem_rdata >> shamt_w;
    lane_mask_w = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt_w;
    merged_w    = (mem_rdata & ~lane_mask_w) | ((wdata_q << shamt_w) & lane_mask_w);
    case (funct3_q)
      3'b000:  load_ext_w = {{24{shifted_w[7]}}, shifted_w[7:0]};
      3'b001:  load_ext_w = {{16{shifted_w[15]}}, shifted_w[15:0]};
      3'b100:  load_ext_w = {24'h0, shifted_w[7:0]};
      3'b101:  load_ext_w = {16'h0, shifted_w[15:0]};
      default: load_ext_w = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_wdata_d  = mem_wdata_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d      = req_store;
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_data_d  = 32'h0;
          resp_fault_d = 1'b0;
          if (fault_w) begin
            resp_fault_d = 1'b1;
            state_d      = RESP;
          end else if (req_store && (req_funct3 == 3'b010)) begin
            mem_wdata_d = req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        if (store_q) begin
          mem_wdata_d = merged_w;
          state_d     = WRITE;
        end else begin
          resp_data_d = load_ext_w;
          state_d     = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Strobes are gated by rst so a reset landing mid-RMW never commits a write.
  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    mem_read   = (state_q == READ) && !rst;
    mem_wr     = (state_q == WRITE) && !rst;
    mem_addr   = {2'b00, addr_q[31:2]};
    mem_wdata  = mem_wdata_q;
    resp_valid = (state_q == RESP);
    resp_fault = resp_fault_q && (state_q == RESP);
    resp_data  = resp_data_q;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access controller sitting between the execute stage and the word-addressed data memory (`memory_reg_file`). It accepts one load/store request at a time from execute and checks alignment and range. It performs byte/halfword stores as read-modify-write over the word-only memory, and returns sign- or zero-extended load data to writeback with a single-cycle response pulse.

## Interface
- NUM_WORDS, 32, data memory depth in 32-bit words; legal byte addresses are 0 .. 4*NUM_WORDS-1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- req_valid  input  1  execute presents a request
- req_ready  output  1  unit accepts a request this cycle
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low bits used for B/H
- mem_read  output  1  read strobe to data memory
- mem_wr  output  1  write strobe to data memory
- mem_addr  output  32  word index (req_addr[31:2]) to data memory
- mem_wdata  output  32  full word to write
- mem_rdata  input  32  registered memory output, valid the cycle after mem_read
- resp_valid  output  1  one-cycle pulse: request complete
- resp_fault  output  1  qualifies resp_valid: request rejected, no memory access made
- resp_data  output  32  extended load data; 0 for stores and faults

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch store, funct3, addr, wdata.
  - Fault → RESP with fault: illegal funct3 (011, 11x, or store with 100/101), misalignment (H/HU with addr[0]=1; W with addr[1:0]≠0), or out of range (addr[31:2] ≥ NUM_WORDS).
  - Aligned SW → WRITE.
  - All loads, SB, SH → READ.
- READ: mem_read=1, mem_addr=latched word index → WAIT.
- WAIT: sample mem_rdata.
  - Load: extract the lane, extend, register into resp_data → RESP.
  - SB/SH: merge the store bytes into the read word and register as mem_wdata → WRITE.
- WRITE: mem_wr=1, mem_addr as latched, mem_wdata = merged word (SB/SH) or req_wdata (SW) → RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_fault and resp_data → IDLE.
- Little-endian lanes:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend bit 7/15; BU/HU zero-extend.
  - SB replaces bits [8k+7:8k] with wdata[7:0]; SH replaces [16k+15:16k] with wdata[15:0]; other bits are preserved.
- mem_read and mem_wr are never high together. Both are decoded from state only (Moore).
- Response is never back-pressured; writeback always consumes resp_valid.
- req_ready=0 in every state except IDLE. Requests presented then are ignored, and execute holds them.

## Timing
- Cycle 0 = the cycle in which req_valid and req_ready are both high.
- Latencies (resp_valid asserted in):
  - Fault: cycle 1.
  - SW: cycle 2; mem_wr in cycle 1.
  - Load: cycle 3; mem_read in cycle 1, data sampled in cycle 2.
  - SB/SH: cycle 4; mem_read in cycle 1, mem_wr in cycle 3.
- Back-to-back throughput: the next request can be accepted in the cycle after RESP.
- Reset values: state=IDLE, resp_valid=0, resp_fault=0, resp_data=0, mem_wdata=0, mem_addr=0, mem_read=0, mem_wr=0.
- req_ready=0 while rst=1.
- Reset mid-operation:
  - rst=1 in any cycle forces mem_wr=0 and mem_read=0 combinationally in that cycle.
  - The in-flight request is dropped with no response.
  - A half-done RMW leaves memory unchanged.
- Faulted requests never assert mem_read or mem_wr.

## Test plan
- Word 3 = 0x8899AABB. LB addr 0x0D → resp_data 0xFFFFFFAA in cycle 3. LBU addr 0x0D → 0x000000AA. LH addr 0x0E → 0xFFFF8899. LHU → 0x00008899.
- SB wdata 0x12345677 addr 0x0E on word 3 = 0x8899AABB → mem_wr cycle 3 with mem_wdata 0x8877AABB, resp_valid cycle 4. A following LW addr 0x0C returns 0x8877AABB.
- SW 0xDEADBEEF addr 0x7C → mem_wr cycle 1, mem_addr 31, resp_valid cycle 2, resp_fault 0.
- Faults, each giving resp_valid+resp_fault in cycle 1 with no mem strobes and resp_data 0:
  - LW addr 0x0E (misaligned).
  - SH addr 0x01 (misaligned).
  - LW addr 0x80 (word 32, out of range).
  - Store with funct3 100 (illegal).
- Back-to-back: SW then LW to the same address, with req_valid held high → second request accepted in the cycle after the first RESP; LW returns the stored value. req_ready is 0 throughout the busy cycles.
- Reset mid-op: rst=1 in the WRITE cycle of an SB → mem_wr=0 that cycle, no resp_valid. After release, the target word is unchanged and req_ready=1.
